// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and limits for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_t;

    localparam int MIN_DIV   = 2;
    localparam int MIN_NBITS = 5;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO, registered count, no fall-through
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Flags come only from the registered count, so a full FIFO refuses a push even while popping.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with runtime frame format
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tx_en,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic [3:0]                      cfg_nbits,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_two_stop,
    input  logic                            s_valid,
    input  logic [DATA_W-1:0]               s_data,
    output logic                            s_ready,
    output logic                            tx_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    tx_state_t         r_state, w_state;
    logic [DATA_W-1:0] r_shift, w_shift;
    logic [DIV_W-1:0]  r_div, w_div;
    logic [DIV_W-1:0]  r_baud, w_baud;
    logic [3:0]        r_nbits, w_nbits;
    logic [3:0]        r_bit, w_bit;
    par_mode_t         r_par, w_par;
    logic              r_par_bit, w_par_bit;
    logic              r_two_stop, w_two_stop;
    logic              r_tx, w_tx;
    logic              r_busy, w_busy;

    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_tick;
    logic              w_start_ok;
    logic              w_load;
    logic [DIV_W-1:0]  w_cfg_div;
    logic [3:0]        w_cfg_nbits;
    par_mode_t         w_cfg_par;
    logic              w_cfg_par_bit;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (s_valid),
        .i_wdata (s_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign s_ready    = !w_full;
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign w_tick     = (r_baud == r_div - DIV_W'(1));
    assign w_start_ok = tx_en && !w_empty;

    // Frame format as it would be latched if a frame started this cycle.
    always_comb begin
        w_cfg_div   = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
        w_cfg_nbits = (cfg_nbits < 4'(MIN_NBITS) || cfg_nbits > 4'(DATA_W)) ? 4'(DATA_W) : cfg_nbits;
        case (cfg_parity)
            2'b01:   w_cfg_par = PAR_EVEN;
            2'b10:   w_cfg_par = PAR_ODD;
            default: w_cfg_par = PAR_NONE;
        endcase
        w_cfg_par_bit = (w_cfg_par == PAR_ODD);
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < w_cfg_nbits) begin
                w_cfg_par_bit = w_cfg_par_bit ^ w_head[i];
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_div      = r_div;
        w_baud     = r_baud;
        w_nbits    = r_nbits;
        w_bit      = r_bit;
        w_par      = r_par;
        w_par_bit  = r_par_bit;
        w_two_stop = r_two_stop;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_pop      = 1'b0;
        w_load     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                w_load = w_start_ok;
            end
            default: begin
                if (!w_tick) begin
                    w_baud = r_baud + DIV_W'(1);
                end else begin
                    w_baud = '0;
                    case (r_state)
                        ST_START: begin
                            w_state = ST_DATA;
                            w_bit   = '0;
                            w_tx    = r_shift[0];
                        end
                        ST_DATA: begin
                            w_shift = r_shift >> 1;
                            if (r_bit == r_nbits - 4'd1) begin
                                w_bit = '0;
                                if (r_par != PAR_NONE) begin
                                    w_state = ST_PARITY;
                                    w_tx    = r_par_bit;
                                end else begin
                                    w_state = ST_STOP;
                                    w_tx    = 1'b1;
                                end
                            end else begin
                                w_bit = r_bit + 4'd1;
                                w_tx  = r_shift[1];
                            end
                        end
                        ST_PARITY: begin
                            w_state = ST_STOP;
                            w_bit   = '0;
                            w_tx    = 1'b1;
                        end
                        default: begin
                            if (r_bit == {3'b000, r_two_stop}) begin
                                w_load = w_start_ok;
                                if (!w_start_ok) begin
                                    w_state = ST_IDLE;
                                    w_busy  = 1'b0;
                                    w_tx    = 1'b1;
                                end
                            end else begin
                                w_bit = r_bit + 4'd1;
                            end
                        end
                    endcase
                end
            end
        endcase

        // Shared frame start from IDLE or straight out of the last stop bit.
        if (w_load) begin
            w_pop      = 1'b1;
            w_state    = ST_START;
            w_shift    = w_head;
            w_div      = w_cfg_div;
            w_nbits    = w_cfg_nbits;
            w_par      = w_cfg_par;
            w_par_bit  = w_cfg_par_bit;
            w_two_stop = cfg_two_stop;
            w_baud     = '0;
            w_bit      = '0;
            w_tx       = 1'b0;
            w_busy     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_div      <= DIV_W'(MIN_DIV);
            r_baud     <= '0;
            r_nbits    <= 4'(DATA_W);
            r_bit      <= '0;
            r_par      <= PAR_NONE;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_div      <= w_div;
            r_baud     <= w_baud;
            r_nbits    <= w_nbits;
            r_bit      <= w_bit;
            r_par      <= w_par;
            r_par_bit  <= w_par_bit;
            r_two_stop <= w_two_stop;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
        end
    end

endmodule
